// File: rtl/fpu_pkg.sv
// fpu_pkg: shared types and constants for the binary32 FPU blocks.
// Holds the rounding-mode and state encodings plus IEEE field constants.
package fpu_pkg;

  typedef enum logic [2:0] {
    FRM_RNE = 3'b000,
    FRM_RTZ = 3'b001,
    FRM_RDN = 3'b010,
    FRM_RUP = 3'b011,
    FRM_RMM = 3'b100
  } frm_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALIGN,
    S_ADD,
    S_NORM,
    S_ROUND,
    S_DONE
  } state_e;

  localparam int          EXP_BIAS   = 127;
  localparam logic [9:0]  EXP_MAX    = 10'(2 * EXP_BIAS + 1);
  localparam logic [31:0] QNAN       = 32'h7FC0_0000;
  localparam logic [30:0] MAX_FINITE = 31'h7F7F_FFFF;
  localparam logic [30:0] INF_MAG    = 31'h7F80_0000;

endpackage

// File: rtl/fpu_lzc.sv
// fpu_lzc: combinational leading-zero counter over a 28-bit field.
// An all-zero input reports 28.
module fpu_lzc (
  input  logic [27:0] i_data,
  output logic [4:0]  o_cnt
);

  always_comb begin
    o_cnt = 5'd28;
    for (int i = 0; i < 28; i++) begin
      if (i_data[i]) o_cnt = 5'(27 - i);
    end
  end

endmodule

// File: rtl/fpu_add.sv
// fpu_add: multi-cycle IEEE-754 binary32 adder.
// One state each for align, add, normalize and round, then a done pulse.
module fpu_add
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] operA_float32,
  input  logic [31:0] operB_float32,
  input  logic [2:0]  frm,
  output logic [31:0] result,
  output logic        done,
  output logic        busy,
  output logic        flag_nx,
  output logic        flag_of,
  output logic        flag_nv
);

  state_e      r_state;
  state_e      w_next;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [2:0]  r_frm;
  logic        r_sign;
  logic        r_sub;
  logic [7:0]  r_exp;
  logic [26:0] r_ml;
  logic [26:0] r_ms;
  logic        r_spec;
  logic        r_spec_nv;
  logic [31:0] r_spec_res;
  logic [27:0] r_sum;
  logic [26:0] r_m;
  logic [9:0]  r_e;
  logic        r_zero;
  logic        r_flush;

  logic [7:0]  w_ea;
  logic [7:0]  w_eb;
  logic [7:0]  w_el;
  logic [7:0]  w_es;
  logic [7:0]  w_diff;
  logic [22:0] w_fa;
  logic [22:0] w_fb;
  logic [22:0] w_fl;
  logic [22:0] w_fs;
  logic        w_a_big;
  logic        w_sl;
  logic [26:0] w_ml;
  logic [26:0] w_ms0;
  logic [26:0] w_ms;
  logic [53:0] w_ext;
  logic        w_nan_a;
  logic        w_nan_b;
  logic        w_inf_a;
  logic        w_inf_b;
  logic        w_snan;
  logic        w_inf_cl;
  logic        w_spec;
  logic        w_spec_nv;
  logic [31:0] w_spec_res;

  logic [27:0] w_sum;
  logic [4:0]  w_lz;
  logic [4:0]  w_shl;
  logic [26:0] w_nm;
  logic [9:0]  w_ne;
  logic        w_nzero;
  logic        w_uflow;
  logic        w_zsign;

  logic        w_g;
  logic        w_r;
  logic        w_s;
  logic        w_grs;
  logic        w_inc;
  logic        w_to_inf;
  logic        w_rcarry;
  logic [22:0] w_frac;
  logic [9:0]  w_re;
  logic        w_ovf;
  logic [31:0] w_res;
  logic        w_nx;
  logic        w_of;
  logic        w_nv;

  // Subnormal inputs collapse to signed zero before the magnitude compare
  assign w_ea    = r_a[30:23];
  assign w_eb    = r_b[30:23];
  assign w_fa    = (w_ea == 8'd0) ? 23'd0 : r_a[22:0];
  assign w_fb    = (w_eb == 8'd0) ? 23'd0 : r_b[22:0];
  assign w_a_big = {w_ea, w_fa} >= {w_eb, w_fb};
  assign w_el    = w_a_big ? w_ea : w_eb;
  assign w_es    = w_a_big ? w_eb : w_ea;
  assign w_fl    = w_a_big ? w_fa : w_fb;
  assign w_fs    = w_a_big ? w_fb : w_fa;
  assign w_sl    = w_a_big ? r_a[31] : r_b[31];
  assign w_diff  = w_el - w_es;
  assign w_ml    = {|w_el, w_fl, 3'b000};
  assign w_ms0   = {|w_es, w_fs, 3'b000};
  assign w_ext   = {w_ms0, 27'd0} >> w_diff;
  assign w_ms    = (w_diff >= 8'd26) ? {26'd0, |w_ms0}
                 : {w_ext[53:28], w_ext[27] | (|w_ext[26:0])};

  assign w_nan_a  = (&w_ea) & (|r_a[22:0]);
  assign w_nan_b  = (&w_eb) & (|r_b[22:0]);
  assign w_inf_a  = (&w_ea) & ~(|r_a[22:0]);
  assign w_inf_b  = (&w_eb) & ~(|r_b[22:0]);
  assign w_snan   = (w_nan_a & ~r_a[22]) | (w_nan_b & ~r_b[22]);
  assign w_inf_cl = w_inf_a & w_inf_b & (r_a[31] ^ r_b[31]);

  always_comb begin
    w_spec     = w_nan_a | w_nan_b | w_inf_a | w_inf_b;
    w_spec_nv  = w_snan | w_inf_cl;
    w_spec_res = r_b;
    if (w_nan_a | w_nan_b | w_inf_cl) w_spec_res = QNAN;
    else if (w_inf_a)                 w_spec_res = r_a;
  end

  assign w_sum = r_sub ? ({1'b0, r_ml} - {1'b0, r_ms})
               : ({1'b0, r_ml} + {1'b0, r_ms});

  fpu_lzc u_lzc (
    .i_data (r_sum),
    .o_cnt  (w_lz)
  );

  // Bit 27 is the carry slot, so the hidden bit lands at 26 after lz-1
  assign w_shl   = w_lz - 5'd1;
  assign w_nm    = r_sum[27] ? {r_sum[27:2], |r_sum[1:0]}
                 : 27'(r_sum << w_shl);
  assign w_ne    = r_sum[27] ? ({2'b00, r_exp} + 10'd1)
                 : ({2'b00, r_exp} - {5'd0, w_shl});
  assign w_nzero = (r_sum == 28'd0);
  assign w_uflow = ~w_nzero & ($signed(w_ne) <= 10'sd0);
  assign w_zsign = r_sub ? (r_frm == FRM_RDN) : r_sign;

  assign w_g   = r_m[2];
  assign w_r   = r_m[1];
  assign w_s   = r_m[0];
  assign w_grs = w_g | w_r | w_s;

  always_comb begin
    w_inc    = 1'b0;
    w_to_inf = 1'b0;
    unique case (1'b1)
      (r_frm == FRM_RNE): begin
        w_inc    = w_g & (w_r | w_s | r_m[3]);
        w_to_inf = 1'b1;
      end
      (r_frm == FRM_RDN): begin
        w_inc    = r_sign & w_grs;
        w_to_inf = r_sign;
      end
      (r_frm == FRM_RUP): begin
        w_inc    = ~r_sign & w_grs;
        w_to_inf = ~r_sign;
      end
      (r_frm == FRM_RMM): begin
        w_inc    = w_g;
        w_to_inf = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_rcarry = w_inc & (&r_m[26:3]);
  assign w_frac   = r_m[25:3] + {22'd0, w_inc};
  assign w_re     = r_e + {9'd0, w_rcarry};
  assign w_ovf    = (w_re >= EXP_MAX);

  always_comb begin
    w_res = {r_sign, w_re[7:0], w_frac};
    w_nx  = w_grs;
    w_of  = 1'b0;
    w_nv  = 1'b0;
    if (r_spec) begin
      w_res = r_spec_res;
      w_nx  = 1'b0;
      w_nv  = r_spec_nv;
    end else if (r_zero) begin
      w_res = {r_sign, 31'd0};
      w_nx  = 1'b0;
    end else if (r_flush) begin
      w_res = {r_sign, 31'd0};
      w_nx  = 1'b1;
    end else if (w_ovf) begin
      w_res = {r_sign, w_to_inf ? INF_MAG : MAX_FINITE};
      w_nx  = 1'b1;
      w_of  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_next = S_ALIGN;
      S_ALIGN: w_next = S_ADD;
      S_ADD:   w_next = S_NORM;
      S_NORM:  w_next = S_ROUND;
      S_ROUND: w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state != S_IDLE);
    done = (r_state == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a        <= '0;
      r_b        <= '0;
      r_frm      <= '0;
      r_sign     <= 1'b0;
      r_sub      <= 1'b0;
      r_exp      <= '0;
      r_ml       <= '0;
      r_ms       <= '0;
      r_spec     <= 1'b0;
      r_spec_nv  <= 1'b0;
      r_spec_res <= '0;
      r_sum      <= '0;
      r_m        <= '0;
      r_e        <= '0;
      r_zero     <= 1'b0;
      r_flush    <= 1'b0;
      result     <= '0;
      flag_nx    <= 1'b0;
      flag_of    <= 1'b0;
      flag_nv    <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= operA_float32;
            r_b     <= operB_float32;
            r_frm   <= frm;
            flag_nx <= 1'b0;
            flag_of <= 1'b0;
            flag_nv <= 1'b0;
          end
        end
        S_ALIGN: begin
          r_sign     <= w_sl;
          r_sub      <= r_a[31] ^ r_b[31];
          r_exp      <= w_el;
          r_ml       <= w_ml;
          r_ms       <= w_ms;
          r_spec     <= w_spec;
          r_spec_nv  <= w_spec_nv;
          r_spec_res <= w_spec_res;
        end
        S_ADD: r_sum <= w_sum;
        S_NORM: begin
          r_m     <= w_nm;
          r_e     <= w_ne;
          r_zero  <= w_nzero;
          r_flush <= w_uflow;
          if (w_nzero) r_sign <= w_zsign;
        end
        S_ROUND: begin
          result  <= w_res;
          flag_nx <= w_nx;
          flag_of <= w_of;
          flag_nv <= w_nv;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_add.sv
// tb_fpu_add: vector table plus handshake/reset sequences for fpu_add.
// Expected results are queued at drive time and checked on each done.
module tb_fpu_add;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] opa = '0;
  logic [31:0] opb = '0;
  logic [2:0]  frm = '0;
  logic [31:0] result;
  logic        done;
  logic        busy;
  logic        flag_nx;
  logic        flag_of;
  logic        flag_nv;

  fpu_add dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .operA_float32 (opa),
    .operB_float32 (opb),
    .frm           (frm),
    .result        (result),
    .done          (done),
    .busy          (busy),
    .flag_nx       (flag_nx),
    .flag_of       (flag_of),
    .flag_nv       (flag_nv)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  rm;
    logic [31:0] res;
    logic        nx;
    logic        of;
    logic        nv;
  } vec_t;

  typedef struct {
    int          id;
    logic [31:0] res;
    logic        nx;
    logic        of;
    logic        nv;
  } exp_t;

  localparam int NV = 27;

  vec_t tv [NV];
  exp_t sb [$];
  int   done_cyc [$];
  int   n_cmp  = 0;
  int   n_bad  = 0;
  int   n_done = 0;
  int   cyc    = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", nm, act, want);
    end
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (busy) begin
      n_cmp++;
      n_bad++;
      $display("FAIL idle_timeout: busy got 1, want 0");
    end
  endtask

  task automatic push(input int id, input vec_t v);
    exp_t e;
    e.id  = id;
    e.res = v.res;
    e.nx  = v.nx;
    e.of  = v.of;
    e.nv  = v.nv;
    sb.push_back(e);
  endtask

  task automatic run_vec(input int id, input vec_t v);
    wait_idle();
    opa   = v.a;
    opb   = v.b;
    frm   = v.rm;
    start = 1'b1;
    push(id, v);
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    exp_t e;
    vec_t v;
    int   lat;
    int   nd0;

    tv[0]  = '{32'h3F800000, 32'h3F800000, 3'd0, 32'h40000000, 0, 0, 0};
    tv[1]  = '{32'h3F800000, 32'hBF800000, 3'd0, 32'h00000000, 0, 0, 0};
    tv[2]  = '{32'h3F800000, 32'hBF800000, 3'd2, 32'h80000000, 0, 0, 0};
    tv[3]  = '{32'h3F800000, 32'h33800000, 3'd0, 32'h3F800000, 1, 0, 0};
    tv[4]  = '{32'h3F800000, 32'h33800000, 3'd3, 32'h3F800001, 1, 0, 0};
    tv[5]  = '{32'h3F800000, 32'h33800000, 3'd4, 32'h3F800001, 1, 0, 0};
    tv[6]  = '{32'h3F800000, 32'h33800000, 3'd1, 32'h3F800000, 1, 0, 0};
    tv[7]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 3'd0, 32'h7F800000, 1, 1, 0};
    tv[8]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 3'd1, 32'h7F7FFFFF, 1, 1, 0};
    tv[9]  = '{32'hFF7FFFFF, 32'hFF7FFFFF, 3'd3, 32'hFF7FFFFF, 1, 1, 0};
    tv[10] = '{32'hFF7FFFFF, 32'hFF7FFFFF, 3'd2, 32'hFF800000, 1, 1, 0};
    tv[11] = '{32'h7F800000, 32'hFF800000, 3'd0, 32'h7FC00000, 0, 0, 1};
    tv[12] = '{32'h7FA00000, 32'h3F800000, 3'd0, 32'h7FC00000, 0, 0, 1};
    tv[13] = '{32'h7FC00000, 32'h3F800000, 3'd0, 32'h7FC00000, 0, 0, 0};
    tv[14] = '{32'h7F800000, 32'h3F800000, 3'd0, 32'h7F800000, 0, 0, 0};
    tv[15] = '{32'h80000000, 32'h80000000, 3'd0, 32'h80000000, 0, 0, 0};
    tv[16] = '{32'h00000000, 32'h80000000, 3'd0, 32'h00000000, 0, 0, 0};
    tv[17] = '{32'h00000000, 32'h80000000, 3'd2, 32'h80000000, 0, 0, 0};
    tv[18] = '{32'h00000001, 32'h3F800000, 3'd0, 32'h3F800000, 0, 0, 0};
    tv[19] = '{32'h40400000, 32'hBF800000, 3'd0, 32'h40000000, 0, 0, 0};
    tv[20] = '{32'h3F800000, 32'hBF7FFFFF, 3'd0, 32'h33800000, 0, 0, 0};
    tv[21] = '{32'h00C00000, 32'h80800000, 3'd0, 32'h00000000, 1, 0, 0};
    tv[22] = '{32'h3F7FFFFF, 32'h33000000, 3'd0, 32'h3F800000, 1, 0, 0};
    tv[23] = '{32'h3F800000, 32'h32000000, 3'd3, 32'h3F800001, 1, 0, 0};
    tv[24] = '{32'hBF800000, 32'hB3800000, 3'd2, 32'hBF800001, 1, 0, 0};
    tv[25] = '{32'h3F800000, 32'h33800000, 3'd7, 32'h3F800000, 1, 0, 0};
    tv[26] = '{32'h33800000, 32'h3F800000, 3'd3, 32'h3F800001, 1, 0, 0};

    fork
      forever begin
        @(negedge clk);
        cyc++;
        if (done) begin
          n_done++;
          done_cyc.push_back(cyc);
          if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL spurious_done: got result %h, want no done",
                     result);
          end else begin
            e = sb.pop_front();
            chk($sformatf("op%0d result", e.id), result, e.res);
            chk($sformatf("op%0d flags nx/of/nv", e.id),
                {29'd0, flag_nx, flag_of, flag_nv},
                {29'd0, e.nx, e.of, e.nv});
          end
        end
      end
    join_none

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset result", result, 32'd0);
    chk("reset done/busy", {30'd0, done, busy}, 32'd0);
    chk("reset flags", {29'd0, flag_nx, flag_of, flag_nv}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < NV; i++) run_vec(i, tv[i]);

    // Latency: accepted at edge N, done seen in the fifth cycle after it
    wait_idle();
    v     = tv[0];
    opa   = v.a;
    opb   = v.b;
    frm   = v.rm;
    start = 1'b1;
    push(100, v);
    @(negedge clk);
    start = 1'b0;
    chk("flags cleared on start", {31'd0, flag_nx}, 32'd0);
    lat = 0;
    while (!done && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk("done latency", lat, 4);

    // start held high: one completion every six cycles
    wait_idle();
    nd0   = n_done;
    v     = tv[19];
    opa   = v.a;
    opb   = v.b;
    frm   = v.rm;
    start = 1'b1;
    push(101, v);
    push(102, v);
    push(103, v);
    repeat (13) @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (2) @(negedge clk);
    chk("held start done count", n_done - nd0, 3);
    if (done_cyc.size() >= 3) begin
      chk("done spacing 1", done_cyc[$] - done_cyc[$-1], 6);
      chk("done spacing 2", done_cyc[$-1] - done_cyc[$-2], 6);
    end

    // start during busy is dropped and captured operands stay put
    wait_idle();
    nd0   = n_done;
    opa   = 32'h3F800000;
    opb   = 32'h40000000;
    frm   = 3'd0;
    start = 1'b1;
    v     = '{32'h3F800000, 32'h40000000, 3'd0, 32'h40400000, 0, 0, 0};
    push(104, v);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    opa   = 32'h7F800000;
    opb   = 32'hFF800000;
    frm   = 3'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (10) @(negedge clk);
    chk("busy start ignored", n_done - nd0, 1);

    // Reset while in ADD aborts the operation
    wait_idle();
    opa   = 32'h40400000;
    opb   = 32'h3F800000;
    frm   = 3'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid reset result", result, 32'd0);
    chk("mid reset done/busy", {30'd0, done, busy}, 32'd0);
    chk("mid reset flags", {29'd0, flag_nx, flag_of, flag_nv}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    nd0 = n_done;
    repeat (10) @(negedge clk);
    chk("no done after abort", n_done - nd0, 0);
    chk("idle after abort", {31'd0, busy}, 32'd0);
    run_vec(105, tv[4]);

    wait_idle();
    lat = 0;
    while (sb.size() != 0 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("scoreboard drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fpu_add.md
FPU_ADD -- requirements
Module: fpu_add

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 start  input  1  request; sampled only in IDLE.
REQ-004 operA_float32  input  32  IEEE-754 binary32 addend A (product from fpu_mul in the FMA path).
REQ-005 operB_float32  input  32  IEEE-754 binary32 addend B.
REQ-006 frm  input  3  rounding mode: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM; others treated as RTZ.
REQ-007 result  output  32  registered sum; valid while done=1 and held until the next completion.
REQ-008 done  output  1  one-cycle completion pulse.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 flag_nx  output  1  inexact; valid with done.
REQ-011 flag_of  output  1  overflow; valid with done.
REQ-012 flag_nv  output  1  invalid operation; valid with done.

Function
REQ-013 Operation: result = round(A + B), using frm as captured at start.
REQ-014 States: IDLE, ALIGN, ADD, NORM, ROUND, DONE.
- IDLE to ALIGN when start=1; operands and frm captured on that edge.
- ALIGN, ADD, NORM, ROUND each last one cycle; DONE returns to IDLE unconditionally.
REQ-015 Latency: start seen at edge N gives done=1 during cycle N+5; a back-to-back start is accepted at the edge leaving DONE+1 (IDLE).
REQ-016 start while busy=1 is ignored; there is no queueing and captured operands do not change.
REQ-017 ALIGN
- Unpack hidden bit (1 for exp!=0).
- Swap so the larger-magnitude operand is first; compare {exp, mantissa}.
- Right-shift the smaller mantissa by the exponent difference into a 27-bit working field {hidden, 23 frac, G, R, S}; shifted-out bits OR into S.
- A difference of 26 or more leaves only S.
REQ-018 ADD: add the magnitudes when the signs are equal, otherwise subtract the smaller from the larger; the result sign is the sign of the larger operand; 28-bit result including carry.
REQ-019 NORM
- On carry: shift right 1, exponent+1, dropped bit ORed into S.
- Otherwise: left-shift by the leading-zero count, exponent minus count.
- If the exponent would fall to 0 or below, the result flushes to signed zero with flag_nx=1.
REQ-020 ROUND
- G/R/S rule per mode: RNE ties-to-even, RTZ truncate, RDN/RUP by sign, RMM ties-away.
- A mantissa carry from rounding increments the exponent and resets the mantissa to 1.0.
REQ-021 flag_nx = G|R|S after normalization (or flush).
REQ-022 Overflow: an exponent of 255 or above sets flag_of=1 and flag_nx=1. The result is:
- +/-inf for RNE and RMM;
- max finite 0x7F7FFFFF (with sign) for RTZ;
- inf for RUP when positive, max finite when negative;
- inf for RDN when negative, max finite when positive.
REQ-023 Exact zero sum with opposite signs gives +0, except RDN gives -0; x + x with both zero keeps the common sign.
REQ-024 Subnormal inputs (exp=0) are treated as signed zero.
REQ-025 Specials
- Any NaN input gives 0x7FC00000; flag_nv=1 only if an input is a signalling NaN.
- inf + (-inf) gives 0x7FC00000 with flag_nv=1.
- inf + finite gives that inf with no flags.
- Specials still take the full 5-cycle latency.
REQ-026 Outputs and flags update only on entry to DONE; flags clear at the next accepted start.

Reset
REQ-027 While rst=1: state=IDLE, result=0, done=0, busy=0, all flags=0, internal registers 0.
REQ-028 Reset asserted mid-operation aborts it; no done pulse appears after release, and the next start begins a fresh operation.

Structure
REQ-029 Shared package fpu_pkg holds:
- the frm encoding enum;
- the state enum;
- constants EXP_BIAS=127, QNAN=32'h7FC00000, MAX_FINITE magnitude 31'h7F7FFFFF.
REQ-030 Sub-module fpu_lzc: combinational 28-bit leading-zero counter (5-bit count), instantiated once for NORM.
REQ-031 Width of fpu_mul output matches the operA_float32 port directly; no adapter is needed.

Verification
REQ-032 0x3F800000 + 0x3F800000, RNE -> result 0x40000000, flags 0, done at N+5.
REQ-033 0x3F800000 + 0xBF800000: RNE -> 0x00000000; RDN -> 0x80000000; flag_nx=0.
REQ-034 0x3F800000 + 0x33800000 (tie): RNE -> 0x3F800000, flag_nx=1; RUP and RMM -> 0x3F800001.
REQ-035 0x7F7FFFFF + 0x7F7FFFFF: RNE -> 0x7F800000 with flag_of=1 and flag_nx=1; RTZ -> 0x7F7FFFFF.
REQ-036 0x7F800000 + 0xFF800000 -> 0x7FC00000 with flag_nv=1; 0x7FA00000 + 0x3F800000 -> 0x7FC00000 with flag_nv=1.
REQ-037 Reset and handshake checks:
- rst pulsed in ADD state -> outputs 0 and no done pulse.
- start held continuously -> one done every 6 cycles.
- start during busy -> ignored.
